ex_mac_hilo: RTL
================

Name: ex_mac_hilo

Overview:
- Execute-stage consumer of the decode outputs (aluop, reg1, reg2, wd, wreg) for the multiply and HI/LO instruction class.
- Covers MULT, MULTU, MUL, MADD, MADDU, MSUB, MSUBU, MFHI, MFLO, MTHI, MTLO.
- Owns the architectural HI/LO registers and runs MADD/MSUB family instructions as a 2-cycle operation, raising a stall request to the pipeline controller.
- Drives registered write-back results (wdata/wd/wreg) toward MEM. These outputs also serve as the ex_* forwarding source for decode.

Parameters:
- DW, 32, data width of reg1/reg2/HI/LO
- AW, 5, register address width
- OPW, 8, aluop width (matches AluOpBus)

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  reset; asynchronous, active-low
- valid_i  in  1  decode→execute slot holds a real instruction
- aluop_i  in  OPW  operation code; uses the shared EXE_*_OP constants
- reg1_i  in  DW  operand 1 (rs, already forwarded)
- reg2_i  in  DW  operand 2 (rt, already forwarded)
- wd_i  in  AW  destination register
- wreg_i  in  1  destination write enable from decode
- stallreq_o  out  1  hold the decode→execute slot this cycle
- wdata_o  out  DW  registered result
- wd_o  out  AW  registered destination
- wreg_o  out  1  registered write enable
- hi_o  out  DW  current HI
- lo_o  out  DW  current LO

Behaviour:
- Reset (rst=0, async): hi/lo=0, wdata_o=0, wd_o=0, wreg_o=0, stallreq_o=0, state=IDLE, acc_prod=0.
- Product rules:
  - signed product (64b) for MULT, MUL, MADD, MSUB; unsigned for MULTU, MADDU, MSUBU.
  - Signed products are computed via two's-complement magnitude and a sign fix-up.
- Instructions accepted only in IDLE with valid_i=1. Other aluops (or valid_i=0) → wreg_o=0 next cycle, HI/LO unchanged.
- Single-cycle ops (result visible at next edge):
  - MULT/MULTU: {hi,lo}←product; wreg_o←0.
  - MUL: wdata_o←product[31:0], wd_o←wd_i, wreg_o←wreg_i; HI/LO unchanged.
  - MFHI/MFLO: wdata_o←hi / lo as currently registered, wd_o←wd_i, wreg_o←wreg_i.
  - MTHI: hi←reg1_i. MTLO: lo←reg1_i. In both cases the other half is unchanged and wreg_o←0.
- MADD/MADDU/MSUB/MSUBU (FSM IDLE→ACC→IDLE):
  - IDLE, op seen: stallreq_o=1 combinationally.
  - At that edge: acc_prod←product (MSUB*: the two's-complement negation of the product); state→ACC; wreg_o←0.
  - ACC: stallreq_o=0. The operation commits at this edge: {hi,lo}←{hi,lo}+acc_prod (mod 2^64); state→IDLE; wreg_o←0. The slot's inputs are ignored in ACC; the controller has held them, and they are the same MADD.
- Net effect: 2 cycles per accumulate; the next instruction is accepted the cycle after ACC.
- Back-to-back HI/LO: an instruction in the cycle after a commit sees the updated HI/LO. There is no internal same-cycle bypass, because commits are registered.
- Wrap-around: 64-bit accumulate overflow wraps silently; no exception.
- MSUB of a zero product leaves HI/LO unchanged.
- Async reset mid-ACC aborts the accumulate: HI/LO are reset, the partial result is discarded, stallreq_o drops immediately.
- stallreq_o is a combinational function of state, valid_i and aluop_i only; no path from wdata_o.

Decomposition:
- Shared defs package holds:
  - EXE_MULT_OP, EXE_MULTU_OP, EXE_MUL_OP, EXE_MADD_OP, EXE_MADDU_OP, EXE_MSUB_OP, EXE_MSUBU_OP, EXE_MFHI_OP, EXE_MFLO_OP, EXE_MTHI_OP, EXE_MTLO_OP
  - RstEnable (=1'b0 for this block), WriteEnable/Disable, ZeroWord
  - FSM state encodings (IDLE, ACC)
- One sub-module, mul32x32: combinational signed/unsigned 32×32→64 multiplier with a sign-select input.

Test Plan:
- Reset, then MTHI reg1=0x12345678; MTLO reg1=0x9ABCDEF0; MFHI wd=3 → wdata_o=0x12345678, wd_o=3, wreg_o=1; next MFLO → 0x9ABCDEF0.
- MULT reg1=0xFFFFFFFF (−1), reg2=2 → hi=0xFFFFFFFF, lo=0xFFFFFFFE. MULTU on the same operands → hi=0x00000001, lo=0xFFFFFFFE.
- MUL reg1=7, reg2=−3, wd=8 → wdata_o=0xFFFFFFEB, wreg_o=1; HI/LO unchanged.
- With hi=0, lo=0xFFFFFFFF: MADDU reg1=1, reg2=1 → stallreq_o=1 in cycle 1 and 0 in cycle 2; after commit hi=1, lo=0 (carry crosses halves).
- With hi=0, lo=5: MSUB reg1=3, reg2=4 → {hi,lo}=0xFFFFFFFF_FFFFFFF9 after 2 cycles; wreg_o=0 throughout.
- Assert rst low during ACC of a MADD → stallreq_o=0, hi=lo=0, wreg_o=0 immediately. After release, an MFLO returns 0.

Source files
------------

// File: rtl/ex_mac_hilo_pkg.sv
// Shared definitions for the execute-stage multiply / HI-LO unit.
// Opcodes match the decode stage AluOpBus encoding.
package ex_mac_hilo_pkg;

  localparam logic [7:0] EXE_MULT_OP  = 8'b0001_1000;
  localparam logic [7:0] EXE_MULTU_OP = 8'b0001_1001;
  localparam logic [7:0] EXE_MUL_OP   = 8'b1010_1001;
  localparam logic [7:0] EXE_MADD_OP  = 8'b1010_0110;
  localparam logic [7:0] EXE_MADDU_OP = 8'b1010_1000;
  localparam logic [7:0] EXE_MSUB_OP  = 8'b1010_1010;
  localparam logic [7:0] EXE_MSUBU_OP = 8'b1010_1011;
  localparam logic [7:0] EXE_MFHI_OP  = 8'b0001_0000;
  localparam logic [7:0] EXE_MFLO_OP  = 8'b0001_0010;
  localparam logic [7:0] EXE_MTHI_OP  = 8'b0001_0001;
  localparam logic [7:0] EXE_MTLO_OP  = 8'b0001_0011;

  localparam logic        RstEnable    = 1'b0;
  localparam logic        WriteEnable  = 1'b1;
  localparam logic        WriteDisable = 1'b0;
  localparam logic [31:0] ZeroWord     = 32'h0;

  typedef enum logic {
    IDLE = 1'b0,
    ACC  = 1'b1
  } mac_state_t;

  function automatic logic is_acc_op(input logic [7:0] op);
    return (op == EXE_MADD_OP) || (op == EXE_MADDU_OP) ||
           (op == EXE_MSUB_OP) || (op == EXE_MSUBU_OP);
  endfunction

endpackage

// File: rtl/ex_mac_hilo_mul32x32.sv
// Combinational 32x32->64 multiplier, signed or unsigned.
// Signed mode multiplies magnitudes and negates the result if needed.
module mul32x32 #(
  parameter int DW = 32
) (
  input  logic [DW-1:0]   a,
  input  logic [DW-1:0]   b,
  input  logic            sgn,
  output logic [2*DW-1:0] p
);

  logic          a_neg;
  logic          b_neg;
  logic [DW-1:0] a_mag;
  logic [DW-1:0] b_mag;
  logic [2*DW-1:0] mag;

  always_comb begin
    a_neg = sgn & a[DW-1];
    b_neg = sgn & b[DW-1];
    a_mag = a_neg ? (~a + 1'b1) : a;
    b_mag = b_neg ? (~b + 1'b1) : b;
    mag   = {{DW{1'b0}}, a_mag} * {{DW{1'b0}}, b_mag};
    p     = (a_neg ^ b_neg) ? (~mag + 1'b1) : mag;
  end

endmodule

// File: rtl/ex_mac_hilo.sv
// Execute stage for multiply and HI/LO instructions.
// Owns HI/LO; MADD/MSUB family takes two cycles and stalls decode.
module ex_mac_hilo
  import ex_mac_hilo_pkg::*;
#(
  parameter int DW  = 32,
  parameter int AW  = 5,
  parameter int OPW = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           valid_i,
  input  logic [OPW-1:0] aluop_i,
  input  logic [DW-1:0]  reg1_i,
  input  logic [DW-1:0]  reg2_i,
  input  logic [AW-1:0]  wd_i,
  input  logic           wreg_i,
  output logic           stallreq_o,
  output logic [DW-1:0]  wdata_o,
  output logic [AW-1:0]  wd_o,
  output logic           wreg_o,
  output logic [DW-1:0]  hi_o,
  output logic [DW-1:0]  lo_o
);

  mac_state_t      state;
  logic [2*DW-1:0] acc_prod;
  logic [2*DW-1:0] prod;

  logic is_mult, is_multu, is_mul;
  logic is_madd, is_maddu, is_msub, is_msubu;
  logic is_mfhi, is_mflo, is_mthi, is_mtlo;
  logic acc_op, sub_op, sgn;

  always_comb begin
    is_mult  = (aluop_i == EXE_MULT_OP);
    is_multu = (aluop_i == EXE_MULTU_OP);
    is_mul   = (aluop_i == EXE_MUL_OP);
    is_madd  = (aluop_i == EXE_MADD_OP);
    is_maddu = (aluop_i == EXE_MADDU_OP);
    is_msub  = (aluop_i == EXE_MSUB_OP);
    is_msubu = (aluop_i == EXE_MSUBU_OP);
    is_mfhi  = (aluop_i == EXE_MFHI_OP);
    is_mflo  = (aluop_i == EXE_MFLO_OP);
    is_mthi  = (aluop_i == EXE_MTHI_OP);
    is_mtlo  = (aluop_i == EXE_MTLO_OP);
    acc_op   = is_acc_op(aluop_i);
    sub_op   = is_msub | is_msubu;
    sgn      = is_mult | is_mul | is_madd | is_msub;
  end

  mul32x32 #(
    .DW(DW)
  ) u_mul (
    .a   (reg1_i),
    .b   (reg2_i),
    .sgn (sgn),
    .p   (prod)
  );

  // Reset gates the request so it drops as soon as rst asserts.
  assign stallreq_o = (rst != RstEnable) & valid_i &
                      (state == IDLE) & acc_op;

  always_ff @(posedge clk or negedge rst) begin
    if (rst == RstEnable) begin
      state    <= IDLE;
      acc_prod <= '0;
      hi_o     <= '0;
      lo_o     <= '0;
      wdata_o  <= '0;
      wd_o     <= '0;
      wreg_o   <= WriteDisable;
    end else begin
      wreg_o <= WriteDisable;
      unique case (state)
        IDLE: begin
          if (valid_i) begin
            unique case (1'b1)
              is_mult, is_multu: begin
                {hi_o, lo_o} <= prod;
              end
              is_mul: begin
                wdata_o <= prod[DW-1:0];
                wd_o    <= wd_i;
                wreg_o  <= wreg_i;
              end
              is_mfhi: begin
                wdata_o <= hi_o;
                wd_o    <= wd_i;
                wreg_o  <= wreg_i;
              end
              is_mflo: begin
                wdata_o <= lo_o;
                wd_o    <= wd_i;
                wreg_o  <= wreg_i;
              end
              is_mthi: hi_o <= reg1_i;
              is_mtlo: lo_o <= reg1_i;
              acc_op: begin
                acc_prod <= sub_op ? (~prod + 1'b1) : prod;
                state    <= ACC;
              end
              default: ;
            endcase
          end
        end
        ACC: begin
          {hi_o, lo_o} <= {hi_o, lo_o} + acc_prod;
          state        <= IDLE;
        end
      endcase
    end
  end

endmodule
